// File: rtl/clock_divider_glitchless_if.sv
// Bundle between the divider and its consumer: run request, ratio, divided clock and status.
// The o_period_done member exists only when CLKDIV_PERIOD_STROBE_EN is defined.
interface clock_divider_glitchless_if #(
    parameter int RATIO_WIDTH = 8
);
    logic                   i_clk_en;
    logic [RATIO_WIDTH-1:0] i_div_ratio;
    logic                   o_div_clk;
    logic                   o_busy;
    logic [RATIO_WIDTH-1:0] o_ratio_active;
`ifdef CLKDIV_PERIOD_STROBE_EN
    logic                   o_period_done;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_busy,
        input  o_ratio_active,
        input  o_period_done
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_busy,
        output o_ratio_active,
        output o_period_done
    );
`else
    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_busy,
        input  o_ratio_active
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_busy,
        output o_ratio_active
    );
`endif
endinterface

// File: rtl/clock_divider_glitchless.sv
// Glitch-free programmable integer divider of i_ref_clk; ratio and enable are only acted on at period boundaries.
// Optional macro CLKDIV_PERIOD_STROBE_EN adds the o_period_done strobe at every LOW-phase boundary.
module clock_divider_glitchless #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                        i_ref_clk,
    input  logic                        i_rst,
    clock_divider_glitchless_if.slave   bus
);
    localparam int CW = RATIO_WIDTH - 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        BYPASS = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   div_q, div_nxt;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_nxt;

    logic [CW-1:0]          half_floor;
    logic [CW-1:0]          h_last;
    logic [CW-1:0]          l_last;
    logic                   req_div;
    logic                   boundary;

    // High phase is ceil(N/2) cycles, low phase floor(N/2); the counters stop at phase length minus one.
    assign half_floor = ratio_q[RATIO_WIDTH-1:1];
    assign h_last     = half_floor - {{(CW-1){1'b0}}, ~ratio_q[0]};
    assign l_last     = half_floor - CNT_ONE;
    assign req_div    = |bus.i_div_ratio[RATIO_WIDTH-1:1];
    assign boundary   = (state == LOW) && (cnt == l_last);

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= 1'b0;
            ratio_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_q   <= div_nxt;
            ratio_q <= ratio_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_q;
        ratio_nxt = ratio_q;
        case (state)
            IDLE: begin
                ratio_nxt = bus.i_div_ratio;
                cnt_nxt   = '0;
                div_nxt   = 1'b0;
                if (bus.i_clk_en) begin
                    if (req_div) begin
                        state_nxt = HIGH;
                        div_nxt   = 1'b1;
                    end else begin
                        state_nxt = BYPASS;
                    end
                end
            end
            HIGH: begin
                if (cnt == h_last) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    div_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            LOW: begin
                if (boundary) begin
                    cnt_nxt = '0;
                    // Enable loss wins over a simultaneous ratio change; IDLE picks the new ratio up afterwards.
                    if (!bus.i_clk_en) begin
                        state_nxt = IDLE;
                        div_nxt   = 1'b0;
                    end else begin
                        ratio_nxt = bus.i_div_ratio;
                        if (req_div) begin
                            state_nxt = HIGH;
                            div_nxt   = 1'b1;
                        end else begin
                            state_nxt = BYPASS;
                            div_nxt   = 1'b0;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            BYPASS: begin
                ratio_nxt = bus.i_div_ratio;
                cnt_nxt   = '0;
                div_nxt   = 1'b0;
                if (!bus.i_clk_en) begin
                    state_nxt = IDLE;
                end else if (req_div) begin
                    state_nxt = HIGH;
                    div_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                div_nxt   = 1'b0;
            end
        endcase
    end

    // Bypass hands i_ref_clk straight through; the registered divider output is low there, so the mux switches on a low register.
    assign bus.o_div_clk      = (state == BYPASS) ? i_ref_clk : div_q;
    assign bus.o_busy         = (state != IDLE);
    assign bus.o_ratio_active = ratio_q;

`ifdef CLKDIV_PERIOD_STROBE_EN
    logic period_done_q;

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= boundary;
        end
    end

    assign bus.o_period_done = period_done_q;
`endif
endmodule
